// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates 256 saturating bins from interior pixels,
// then streams them out in index order over a valid/ready handshake.
module lbp_hist #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             lbp_finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [CNT_W-1:0] pix_count,
  output logic [7:0]       drop_count,
  output logic             done
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] bin_q [256];
  logic [CNT_W-1:0] pix_q;
  logic [7:0]       drop_q;
  logic [7:0]       idx_q;

  logic [6:0] row;
  logic [6:0] col;
  logic       interior;
  logic       take;
  logic       reject;

  // Rows/cols 0 and 127 have no full 3x3 neighbourhood, so their codes are junk.
  always_comb begin
    row      = lbp_addr[13:7];
    col      = lbp_addr[6:0];
    interior = (row != '0) && (row != '1) && (col != '0) && (col != '1);
    take     = (state_q == ACCUM) && lbp_valid && interior;
    reject   = (state_q == ACCUM) && lbp_valid && !interior;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      for (int unsigned i = 0; i < 256; i++) bin_q[i] <= '0;
      pix_q   <= '0;
      drop_q  <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (take) begin
            if (bin_q[lbp_data] != '1) bin_q[lbp_data] <= bin_q[lbp_data] + 1'b1;
            if (pix_q != '1) pix_q <= pix_q + 1'b1;
          end
          if (reject && (drop_q != '1)) drop_q <= drop_q + 1'b1;
          if (lbp_finish) begin
            state_q <= DRAIN;
            idx_q   <= '0;
          end
        end
        DRAIN: begin
          if (hist_ready) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == 8'hFF) state_q <= DONE;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= ACCUM;
      endcase
    end
  end

  always_comb begin
    hist_valid = (state_q == DRAIN);
    done       = (state_q == DONE);
    hist_bin   = hist_valid ? idx_q : '0;
    hist_count = hist_valid ? bin_q[idx_q] : '0;
    pix_count  = pix_q;
    drop_count = drop_q;
  end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed, table-driven bench for lbp_hist with hand-computed expectations.
module tb_lbp_hist;

  localparam int CNT_W = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             lbp_finish;
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic [CNT_W-1:0] pix_count;
  logic [7:0]       drop_count;
  logic             done;

  lbp_hist #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .lbp_finish (lbp_finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .pix_count  (pix_count),
    .drop_count (drop_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [6:0] row;
    logic [6:0] col;
    logic [7:0] data;
    logic       fin;
    int         exp_pix;
    int         exp_drop;
    logic       exp_hv;
  } vec_t;

  vec_t tbl [10];
  int   exp_bin [256];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [6:0] r, input logic [6:0] c,
                      input logic [7:0] d, input logic f);
    lbp_valid  = v;
    lbp_addr   = {r, c};
    lbp_data   = d;
    lbp_finish = f;
    tick();
    lbp_valid  = 1'b0;
    lbp_finish = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_bin[i] = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix"},   pix_count, 0);
    check({tag, "_drop"},  drop_count, 0);
    check({tag, "_hv"},    hist_valid, 0);
    check({tag, "_bin"},   hist_bin, 0);
    check({tag, "_count"}, hist_count, 0);
    check({tag, "_done"},  done, 0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    lbp_valid  = 1'b0;
    lbp_finish = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    hist_ready = 1'b0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
  endtask

  // Walks the drain; every cycle the presented bin must be the next unaccepted index.
  task automatic drain(input bit rnd);
    int k = 0;
    int cyc = 0;
    while (k < 256 && cyc < 3000) begin
      check("drain_hv", hist_valid, 1);
      check("drain_bin", hist_bin, k);
      check("drain_count", hist_count, exp_bin[k]);
      check("drain_done", done, 0);
      hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
      if (hist_ready) k++;
    end
    hist_ready = 1'b0;
    check("drain_accepts", k, 256);
    if (!rnd) check("drain_cycles", cyc, 256);
    check("done_after_drain", done, 1);
    check("hv_after_drain", hist_valid, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 7'd5,   7'd5,   8'h11, 1'b0, 1, 0, 1'b0};
    tbl[1] = '{1'b1, 7'd5,   7'd6,   8'h11, 1'b0, 2, 0, 1'b0};
    tbl[2] = '{1'b0, 7'd5,   7'd7,   8'h11, 1'b0, 2, 0, 1'b0};
    tbl[3] = '{1'b1, 7'd0,   7'd5,   8'h11, 1'b0, 2, 1, 1'b0};
    tbl[4] = '{1'b1, 7'd127, 7'd5,   8'h11, 1'b0, 2, 2, 1'b0};
    tbl[5] = '{1'b1, 7'd5,   7'd127, 8'h11, 1'b0, 2, 3, 1'b0};
    tbl[6] = '{1'b1, 7'd5,   7'd0,   8'h11, 1'b0, 2, 4, 1'b0};
    tbl[7] = '{1'b1, 7'd1,   7'd1,   8'hFF, 1'b0, 3, 4, 1'b0};
    tbl[8] = '{1'b1, 7'd126, 7'd126, 8'h00, 1'b0, 4, 4, 1'b0};
    tbl[9] = '{1'b1, 7'd1,   7'd126, 8'h11, 1'b1, 5, 4, 1'b1};

    // Border rejection, back-to-back hits, code coincident with finish
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].v, tbl[i].row, tbl[i].col, tbl[i].data, tbl[i].fin);
      check($sformatf("tbl%0d_pix", i), pix_count, tbl[i].exp_pix);
      check($sformatf("tbl%0d_drop", i), drop_count, tbl[i].exp_drop);
      check($sformatf("tbl%0d_hv", i), hist_valid, tbl[i].exp_hv);
    end
    clear_exp();
    exp_bin[8'h11] = 3;
    exp_bin[8'hFF] = 1;
    exp_bin[8'h00] = 1;
    drain(1'b1);
    send(1'b1, 7'd9, 7'd9, 8'h11, 1'b1);
    check("done_ignore_pix", pix_count, 5);
    check("done_ignore_drop", drop_count, 4);
    check("done_hold", done, 1);

    // Cyclic codes with valid gaps: every bin = 4
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      if (i % 3 == 2) send(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      send(1'b1, 7'(1 + i / 64), 7'(1 + i % 64), 8'(i % 256), 1'b0);
    end
    check("cyc_pix", pix_count, 1024);
    check("cyc_drop", drop_count, 0);
    send(1'b0, 7'd0, 7'd0, 8'h00, 1'b1);
    for (int i = 0; i < 256; i++) exp_bin[i] = 4;
    drain(1'b0);

    // Reset mid-drain, then a fresh stream starting in the first cycle after release
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b1, 7'd3, 7'(3 + i), 8'h07, 1'b0);
    send(1'b0, 7'd0, 7'd0, 8'h00, 1'b1);
    hist_ready = 1'b1;
    repeat (100) tick();
    check("mid_drain_bin", hist_bin, 100);
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    hist_ready = 1'b0;
    tick();
    reset = 1'b0;
    send(1'b1, 7'd2, 7'd2, 8'hC3, 1'b0);
    check("post_rst_pix", pix_count, 1);
    check("post_rst_hv", hist_valid, 0);
    send(1'b0, 7'd0, 7'd0, 8'h00, 1'b1);
    clear_exp();
    exp_bin[8'hC3] = 1;
    drain(1'b0);

    // Full interior frame of one code
    do_reset();
    for (int r = 1; r <= 126; r++)
      for (int c = 1; c <= 126; c++)
        send(1'b1, 7'(r), 7'(c), 8'h5A, 1'b0);
    check("frame_pix", pix_count, 15876);
    send(1'b0, 7'd0, 7'd0, 8'h00, 1'b1);
    clear_exp();
    exp_bin[8'h5A] = 15876;
    drain(1'b0);
    check("frame_pix_hold", pix_count, 15876);

    // Saturation of a bin, pix_count and drop_count
    do_reset();
    for (int i = 0; i < 16390; i++) send(1'b1, 7'd1, 7'd1, 8'h33, 1'b0);
    check("sat_pix", pix_count, 16383);
    for (int i = 0; i < 254; i++) send(1'b1, 7'd127, 7'd9, 8'h33, 1'b0);
    check("drop_254", drop_count, 254);
    for (int i = 0; i < 6; i++) send(1'b1, 7'd0, 7'd9, 8'h33, 1'b0);
    check("sat_drop", drop_count, 255);
    check("sat_pix_hold", pix_count, 16383);
    send(1'b0, 7'd0, 7'd0, 8'h00, 1'b1);
    clear_exp();
    exp_bin[8'h33] = 16383;
    drain(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
